reg_pipeline: RTL and testbench
===============================

REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 Parameter WIDTH, default 6: data width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal range 1..16.
REQ-003 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into every data stage on reset.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port D, input, WIDTH: input data word.
REQ-007 Port in_valid, input, 1: D carries a valid word.
REQ-008 Port in_ready, output, 1: pipeline accepts D this cycle.
REQ-009 Port en, input, 1: global advance enable; 0 freezes the pipeline.
REQ-010 Port flush, input, 1: synchronous clear of all valid bits.
REQ-011 Port Q, output, WIDTH: data of the last stage.
REQ-012 Port out_valid, output, 1: Q carries a valid word.
REQ-013 Port out_ready, input, 1: consumer accepts Q this cycle.
REQ-014 Port occupancy, output, clog2(DEPTH+1): number of valid stages.

Function
REQ-015 The block SHALL hold DEPTH stages, each with a WIDTH-bit data register and a valid bit; stage 0 is the input stage and stage DEPTH-1 drives Q.
REQ-016 An input transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1.
REQ-017 An output transfer SHALL occur on a rising edge when out_valid=1 and out_ready=1.
REQ-018 out_valid SHALL equal valid[DEPTH-1] AND en AND NOT flush.
REQ-019 Stage i SHALL advance its word to stage i+1 when valid[i]=1 and stage i+1 is empty or also advancing, with en=1 and flush=0.
REQ-020 The last stage SHALL be treated as advancing when an output transfer occurs.
REQ-021 Bubbles SHALL collapse: a valid word moves forward into any empty downstream stage without waiting for out_ready.
REQ-022 in_ready SHALL equal en AND NOT flush AND (valid[0]=0 OR stage 0 advancing); it is combinational from out_ready.
REQ-023 With en=1, flush=0, out_ready held 1 and an empty pipeline, a word accepted at edge n SHALL appear with out_valid=1 after edge n+DEPTH-1, giving DEPTH-cycle latency and one word per cycle throughput.
REQ-024 When all stages are valid and out_ready=0, in_ready SHALL be 0 and no stage SHALL change.
REQ-025 When all stages are valid and out_ready=1, a simultaneous input and output transfer SHALL be allowed, keeping occupancy at DEPTH.
REQ-026 With en=0 and flush=0, all data and valid registers SHALL hold, and in_ready and out_valid SHALL be 0.
REQ-027 With flush=1, every valid bit SHALL clear on the edge regardless of en, and no input or output transfer SHALL occur; flush wins over a concurrent in_valid.
REQ-028 Data registers SHALL load only on a transfer into their stage and otherwise hold, including through a flush; Q retains its last value while out_valid=0.
REQ-029 occupancy SHALL be a registered count equal to the number of set valid bits, updated by +1 on input only, -1 on output only, unchanged on both or neither, and 0 after a flush.
REQ-030 occupancy SHALL never exceed DEPTH or underflow below 0.
REQ-031 DEPTH=1 SHALL behave as a single elastic register with in_ready = en AND NOT flush AND (NOT valid[0] OR out_ready).

Reset
REQ-032 While reset=1, all valid bits SHALL be 0, all data stages SHALL be RESET_VAL, and occupancy SHALL be 0, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight words immediately; the first transfer SHALL be possible on the first rising edge after reset deasserts.
REQ-034 in_ready and out_valid SHALL be 0 while reset=1.

Verification (WIDTH=6, DEPTH=2 unless stated)
REQ-035 Stream: en=1, out_ready=1, in_valid=1 with D=1,2,3 on consecutive edges -> Q=1,2,3 with out_valid=1 two cycles later on consecutive cycles, occupancy steady at 2.
REQ-036 Backpressure: fill with 5,6, then out_ready=0 -> occupancy=2, in_ready=0, Q=5 held; raise out_ready for 2 cycles -> Q=5 then 6, occupancy returns to 0.
REQ-037 Freeze: 2 words in flight, en=0 for 3 cycles -> registers unchanged, out_valid=0, in_ready=0; en=1 -> stream resumes with no loss or duplication.
REQ-038 Flush: occupancy=2, flush=1 with in_valid=1 and D=9 -> next cycle occupancy=0, out_valid=0, D=9 never appears at Q.
REQ-039 Async reset: reset pulsed between clock edges with occupancy=1 -> occupancy=0 and Q=RESET_VAL before the next edge.
REQ-040 DEPTH=1, RESET_VAL=6'h2A: after reset Q=0x2A; full with out_ready=1 and in_valid=1 -> in_ready=1 and back-to-back transfers every cycle.

Source files
------------

// File: rtl/reg_pipeline.sv
// Elastic register pipeline of DEPTH valid/data stages with bubble collapse; DEPTH-cycle latency.
// Backpressure from out_ready ripples back combinationally to in_ready; en=0 freezes, flush drops all words.
module reg_pipeline #(
  parameter int               WIDTH     = 6,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           D,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       en,
  input  logic                       flush,
  output logic [WIDTH-1:0]           Q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] valid_nxt;
  logic             go;
  logic             room0;
  logic             in_xfer;
  logic             out_xfer;

  assign go = en & ~flush;

  // Walk from the output back: a stage may move if the one ahead is empty or itself moving.
  always_comb begin : advance
    logic room;
    room = out_ready;
    adv  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      adv[i] = go & valid[i] & room;
      room   = ~valid[i] | room;
    end
    room0 = room;
  end

  assign in_ready  = go & room0 & ~reset;
  assign out_valid = go & valid[DEPTH-1] & ~reset;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = adv[DEPTH-1];
  assign Q         = data[DEPTH-1];

  always_comb begin
    valid_nxt    = valid;
    valid_nxt[0] = in_xfer | (valid[0] & ~adv[0]);
    for (int i = 1; i < DEPTH; i++) begin
      valid_nxt[i] = adv[i-1] | (valid[i] & ~adv[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
    end else begin
      valid <= flush ? '0 : valid_nxt;
      if (flush) begin
        occupancy <= '0;
      end else if (in_xfer != out_xfer) begin
        occupancy <= in_xfer ? occupancy + OW'(1) : occupancy - OW'(1);
      end
      // Data registers only load on a move into their stage, so flush leaves them intact.
      if (in_xfer) begin
        data[0] <= D;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          data[i] <= data[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: a DEPTH=2 and a DEPTH=1 instance share stimulus and are checked against a queue model.
module tb_reg_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [5:0] d;

  logic       ir0, ov0, ir1, ov1;
  logic [5:0] q0, q1;
  logic [1:0] occ0;
  logic [0:0] occ1;

  always #5 clk = ~clk;

  reg_pipeline #(.WIDTH(6), .DEPTH(2), .RESET_VAL(6'h00)) dut (
    .clk(clk), .reset(reset), .D(d), .in_valid(in_valid), .in_ready(ir0), .en(en),
    .flush(flush), .Q(q0), .out_valid(ov0), .out_ready(out_ready), .occupancy(occ0)
  );

  reg_pipeline #(.WIDTH(6), .DEPTH(1), .RESET_VAL(6'h2A)) dut1 (
    .clk(clk), .reset(reset), .D(d), .in_valid(in_valid), .in_ready(ir1), .en(en),
    .flush(flush), .Q(q1), .out_valid(ov1), .out_ready(out_ready), .occupancy(occ1)
  );

  logic        obs_ir [2];
  logic        obs_ov [2];
  logic [5:0]  obs_q  [2];
  logic [31:0] obs_occ[2];
  assign obs_ir[0] = ir0;  assign obs_ir[1] = ir1;
  assign obs_ov[0] = ov0;  assign obs_ov[1] = ov1;
  assign obs_q[0]  = q0;   assign obs_q[1]  = q1;
  assign obs_occ[0] = 32'(occ0);
  assign obs_occ[1] = 32'(occ1);

  // Model: an ordered list of words (index 0 = oldest), each with a stage position.
  int         m_depth[2];
  int         m_n[2];
  int         m_pos[2][16];
  logic [5:0] m_dat[2][16];
  logic [5:0] m_q[2];
  logic [5:0] m_rv[2];

  logic       e_ir[2];
  logic       e_ov[2];
  logic [5:0] e_q[2];
  int         e_occ[2];

  int checks = 0;
  int passed = 0;

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_n[id] = 0;
      m_q[id] = m_rv[id];
    end
  endtask

  task automatic model_step(input int id);
    int   dep;
    int   lim;
    int   np;
    logic go;
    dep = m_depth[id];
    go  = en && !flush;
    e_q[id]   = m_q[id];
    e_occ[id] = m_n[id];
    e_ov[id]  = go && (m_n[id] > 0) && (m_pos[id][0] == dep-1);
    e_ir[id]  = 1'b0;
    if (e_ov[id] && out_ready) begin
      for (int k = 0; k < m_n[id]-1; k++) begin
        m_pos[id][k] = m_pos[id][k+1];
        m_dat[id][k] = m_dat[id][k+1];
      end
      m_n[id]--;
    end
    if (go) begin
      for (int k = 0; k < m_n[id]; k++) begin
        lim = (k == 0) ? dep-1 : m_pos[id][k-1]-1;
        np  = m_pos[id][k] + 1;
        if (np > lim) np = lim;
        if (np == dep-1 && m_pos[id][k] != dep-1) m_q[id] = m_dat[id][k];
        m_pos[id][k] = np;
      end
      if (m_n[id] == 0) e_ir[id] = 1'b1;
      else              e_ir[id] = (m_pos[id][m_n[id]-1] >= 1);
      if (in_valid && e_ir[id]) begin
        m_pos[id][m_n[id]] = 0;
        m_dat[id][m_n[id]] = d;
        if (dep == 1) m_q[id] = d;
        m_n[id]++;
      end
    end
    if (flush) m_n[id] = 0;
  endtask

  task automatic step(input logic e, input logic fl, input logic iv, input logic [5:0] dv, input logic ordy);
    @(negedge clk);
    en = e; flush = fl; in_valid = iv; d = dv; out_ready = ordy;
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    for (int id = 0; id < 2; id++) begin
      checks++; if (obs_q[id] !== m_rv[id]) $display("FAIL reset_q[%0d]: got %h expected %h", id, obs_q[id], m_rv[id]); else passed++;
      checks++; if (obs_occ[id] !== 32'd0) $display("FAIL reset_occ[%0d]: got %0d expected 0", id, obs_occ[id]); else passed++;
      checks++; if (obs_ov[id] !== 1'b0) $display("FAIL reset_ov[%0d]: got %b expected 0", id, obs_ov[id]); else passed++;
      checks++; if (obs_ir[id] !== 1'b0) $display("FAIL reset_ir[%0d]: got %b expected 0", id, obs_ir[id]); else passed++;
    end
    @(posedge clk); #1;
    checks++; if (occ0 !== 2'd0 || ov0 !== 1'b0) $display("FAIL reset_hold: got occ=%0d ov=%b expected occ=0 ov=0", occ0, ov0); else passed++;
    checks++; if (q1 !== 6'h2A) $display("FAIL reset_hold_q1: got %h expected 2a", q1); else passed++;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [5:0] exp_q[3];
    int         exp_occ[3];
    exp_q   = '{6'd1, 6'd2, 6'd3};
    exp_occ = '{2, 2, 1};
    do_reset();
    step(1, 0, 1, 6'd1, 1);
    checks++; if (ir0 !== 1'b1) $display("FAIL stream_ir: got %b expected 1", ir0); else passed++;
    step(1, 0, 1, 6'd2, 1);
    checks++; if (ov0 !== 1'b0 || occ0 !== 2'd1) $display("FAIL stream_fill: got ov=%b occ=%0d expected ov=0 occ=1", ov0, occ0); else passed++;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) step(1, 0, 1, 6'd3, 1);
      else        step(1, 0, 0, 6'd0, 1);
      checks++; if (ov0 !== 1'b1 || q0 !== exp_q[k]) $display("FAIL stream_q[%0d]: got ov=%b q=%0d expected ov=1 q=%0d", k, ov0, q0, exp_q[k]); else passed++;
      checks++; if (32'(occ0) !== 32'(exp_occ[k])) $display("FAIL stream_occ[%0d]: got %0d expected %0d", k, occ0, exp_occ[k]); else passed++;
    end
    step(1, 0, 0, 6'd0, 1);
    checks++; if (ov0 !== 1'b0 || occ0 !== 2'd0) $display("FAIL stream_drain: got ov=%b occ=%0d expected ov=0 occ=0", ov0, occ0); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1, 0, 1, 6'd5, 0);
    step(1, 0, 1, 6'd6, 0);
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 1, 6'd7, 0);
      checks++; if (occ0 !== 2'd2 || ir0 !== 1'b0) $display("FAIL bp_full[%0d]: got occ=%0d ir=%b expected occ=2 ir=0", k, occ0, ir0); else passed++;
      checks++; if (q0 !== 6'd5 || ov0 !== 1'b1) $display("FAIL bp_hold[%0d]: got q=%0d ov=%b expected q=5 ov=1", k, q0, ov0); else passed++;
    end
    step(1, 0, 0, 6'd0, 1);
    checks++; if (q0 !== 6'd5 || ov0 !== 1'b1) $display("FAIL bp_out0: got q=%0d ov=%b expected q=5 ov=1", q0, ov0); else passed++;
    step(1, 0, 0, 6'd0, 1);
    checks++; if (q0 !== 6'd6 || ov0 !== 1'b1) $display("FAIL bp_out1: got q=%0d ov=%b expected q=6 ov=1", q0, ov0); else passed++;
    step(1, 0, 0, 6'd0, 1);
    checks++; if (occ0 !== 2'd0 || ov0 !== 1'b0) $display("FAIL bp_empty: got occ=%0d ov=%b expected occ=0 ov=0", occ0, ov0); else passed++;
  endtask

  task automatic test_freeze();
    do_reset();
    step(1, 0, 1, 6'd11, 0);
    step(1, 0, 1, 6'd12, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 6'd13, 1);
      checks++; if (ov0 !== 1'b0 || ir0 !== 1'b0) $display("FAIL freeze_hs[%0d]: got ov=%b ir=%b expected 0 0", k, ov0, ir0); else passed++;
      checks++; if (occ0 !== 2'd2 || q0 !== 6'd11) $display("FAIL freeze_hold[%0d]: got occ=%0d q=%0d expected occ=2 q=11", k, occ0, q0); else passed++;
    end
    step(1, 0, 0, 6'd0, 1);
    checks++; if (ov0 !== 1'b1 || q0 !== 6'd11) $display("FAIL freeze_resume0: got ov=%b q=%0d expected ov=1 q=11", ov0, q0); else passed++;
    step(1, 0, 0, 6'd0, 1);
    checks++; if (ov0 !== 1'b1 || q0 !== 6'd12) $display("FAIL freeze_resume1: got ov=%b q=%0d expected ov=1 q=12", ov0, q0); else passed++;
    step(1, 0, 0, 6'd0, 1);
    checks++; if (ov0 !== 1'b0 || occ0 !== 2'd0) $display("FAIL freeze_drain: got ov=%b occ=%0d expected ov=0 occ=0", ov0, occ0); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 0, 1, 6'd20, 0);
    step(1, 0, 1, 6'd21, 0);
    step(1, 1, 1, 6'd9, 1);
    checks++; if (ov0 !== 1'b0 || ir0 !== 1'b0 || occ0 !== 2'd2) $display("FAIL flush_cycle: got ov=%b ir=%b occ=%0d expected 0 0 2", ov0, ir0, occ0); else passed++;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 6'd0, 1);
      checks++; if (occ0 !== 2'd0 || ov0 !== 1'b0) $display("FAIL flush_empty[%0d]: got occ=%0d ov=%b expected occ=0 ov=0", k, occ0, ov0); else passed++;
      checks++; if (q0 !== 6'd20) $display("FAIL flush_q[%0d]: got %0d expected 20", k, q0); else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 1, 6'd7, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (occ0 !== 2'd1) $display("FAIL areset_pre: got occ=%0d expected 1", occ0); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (occ0 !== 2'd0 || q0 !== 6'd0 || ov0 !== 1'b0) $display("FAIL areset_during: got occ=%0d q=%h ov=%b expected 0 00 0", occ0, q0, ov0); else passed++;
    checks++; if (q1 !== 6'h2A || occ1 !== 1'b0) $display("FAIL areset_d1: got q=%h occ=%0d expected 2a 0", q1, occ1); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (occ0 !== 2'd0 || q0 !== 6'd0) $display("FAIL areset_after: got occ=%0d q=%h expected 0 00", occ0, q0); else passed++;
    model_reset();
    step(1, 0, 1, 6'd8, 1);
    checks++; if (ir0 !== 1'b1) $display("FAIL areset_first_xfer: got ir=%b expected 1", ir0); else passed++;
  endtask

  task automatic test_depth1();
    do_reset();
    step(1, 0, 1, 6'd30, 0);
    checks++; if (ir1 !== 1'b1 || q1 !== 6'h2A) $display("FAIL d1_empty: got ir=%b q=%h expected 1 2a", ir1, q1); else passed++;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 6'(31 + k), 1);
      checks++; if (ir1 !== 1'b1 || ov1 !== 1'b1) $display("FAIL d1_b2b_hs[%0d]: got ir=%b ov=%b expected 1 1", k, ir1, ov1); else passed++;
      checks++; if (q1 !== 6'(30 + k) || occ1 !== 1'b1) $display("FAIL d1_b2b_q[%0d]: got q=%0d occ=%0d expected q=%0d occ=1", k, q1, occ1, 30 + k); else passed++;
    end
    step(1, 0, 1, 6'd40, 0);
    checks++; if (ir1 !== 1'b0 || q1 !== 6'd33) $display("FAIL d1_stall: got ir=%b q=%0d expected 0 33", ir1, q1); else passed++;
  endtask

  task automatic test_random();
    logic e, fl, iv, ordy;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      e    = ($urandom_range(0, 7) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(e, fl, iv, 6'($urandom_range(0, 63)), ordy);
      for (int id = 0; id < 2; id++) begin
        checks++; if (obs_ir[id] !== e_ir[id]) $display("FAIL rnd_ir[%0d] cyc%0d: got %b expected %b", id, n, obs_ir[id], e_ir[id]); else passed++;
        checks++; if (obs_ov[id] !== e_ov[id]) $display("FAIL rnd_ov[%0d] cyc%0d: got %b expected %b", id, n, obs_ov[id], e_ov[id]); else passed++;
        checks++; if (obs_q[id] !== e_q[id]) $display("FAIL rnd_q[%0d] cyc%0d: got %h expected %h", id, n, obs_q[id], e_q[id]); else passed++;
        checks++; if (obs_occ[id] !== 32'(e_occ[id])) $display("FAIL rnd_occ[%0d] cyc%0d: got %0d expected %0d", id, n, obs_occ[id], e_occ[id]); else passed++;
      end
    end
  endtask

  initial begin
    m_depth[0] = 2; m_rv[0] = 6'h00;
    m_depth[1] = 1; m_rv[1] = 6'h2A;
    reset = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; d = 6'h15;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_freeze();
    test_flush();
    test_async_reset();
    test_depth1();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
